mem_store_fwd_buffer: RTL and testbench

//  Parametrised store buffer for the RV32IM pipeline. Sits between the MEM stage and the data cache.

---
 rtl/mem_fwd_pkg.sv | 24 ++
 rtl/mem_fwd_lane_sel.sv | 37 +++
 rtl/mem_store_fwd_buffer.sv | 139 +++++++++++++
 tb/tb_mem_store_fwd_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fwd_pkg.sv
// Shared types for the store-forwarding buffer: entry layout, word offset, and age helper.
// Pure declarations; no latency. No backpressure.
// Entry widths follow SB_ADDR_W/SB_DATA_W; the top's ADDR_W/DATA_W must match them.
package mem_fwd_pkg;

    localparam int SB_ADDR_W     = 32;
    localparam int SB_DATA_W     = 32;
    localparam int SB_NB         = SB_DATA_W / 8;
    localparam int WORD_OFS_BITS = 2;

    typedef struct packed {
        logic                          valid;
        logic [SB_ADDR_W-3:0]          word_addr;
        logic [SB_DATA_W-1:0]          data;
        logic [SB_NB-1:0]              bmask;
    } sb_entry_t;

    // Distance of a slot from the head; larger means younger.
    function automatic int unsigned age_of(input int unsigned ptr, input int unsigned head,
                                           input int unsigned depth);
        return (ptr + depth - head) % depth;
    endfunction

endpackage

// File: rtl/mem_fwd_lane_sel.sv
// Youngest-match priority select for one byte lane of the store buffer.
// Combinational, zero latency.
// No backpressure.
module mem_fwd_lane_sel
    import mem_fwd_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         hit_i,
    input  logic [DEPTH-1:0][7:0]    byte_i,
    input  logic [DEPTH-1:0][PW-1:0] age_i,
    output logic                     cov_o,
    output logic [7:0]               byte_o
);

    logic          found;
    logic [PW-1:0] best_age;
    logic [7:0]    best_byte;

    always_comb begin
        found     = 1'b0;
        best_age  = '0;
        best_byte = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (hit_i[k] && (!found || age_i[k] > best_age)) begin
                found     = 1'b1;
                best_age  = age_i[k];
                best_byte = byte_i[k];
            end
        end
    end

    assign cov_o  = found;
    assign byte_o = best_byte;

endmodule

// File: rtl/mem_store_fwd_buffer.sv
// Store buffer between MEM and D$: FIFO of committed stores with byte-granular load forwarding.
// Lookup is combinational (zero latency); head drains when !MEM_BUSYWAIT; ST_READY low when full.
// Optional MEM_FWD_COALESCE_EN merges a store into the youngest entry on word-address match.
module mem_store_fwd_buffer
    import mem_fwd_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int NB     = DATA_W / 8,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ST_VALID,
    output logic              ST_READY,
    input  logic [ADDR_W-1:0] ST_ADDR,
    input  logic [DATA_W-1:0] ST_DATA,
    input  logic [NB-1:0]     ST_BMASK,
    input  logic              LD_VALID,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [NB-1:0]     LD_BMASK,
    output logic              LD_HIT,
    output logic              LD_PARTIAL,
    output logic [DATA_W-1:0] LD_DATA,
    output logic              MEM_WRITE_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    output logic [NB-1:0]     MEM_BMASK,
    input  logic              MEM_BUSYWAIT,
    output logic [CW-1:0]     COUNT
);

    sb_entry_t           entries_q [DEPTH];
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d, young_idx;
    logic [CW-1:0]       count_q, count_d;
    logic                push, alloc, pop, merge_hit;
    logic [ADDR_W-3:0]   st_word, ld_word;
    sb_entry_t           head_e;
    logic                unused_ofs;

    assign st_word    = ST_ADDR[ADDR_W-1:WORD_OFS_BITS];
    assign ld_word    = LD_ADDR[ADDR_W-1:WORD_OFS_BITS];
    assign unused_ofs = ^{ST_ADDR[WORD_OFS_BITS-1:0], LD_ADDR[WORD_OFS_BITS-1:0]};
    assign young_idx  = tail_q - 1'b1;
    assign head_e     = entries_q[head_q];

`ifdef MEM_FWD_COALESCE_EN
    // COUNT >= 2 keeps the merge target away from the head the cache may be writing.
    assign merge_hit = ST_VALID && (count_q >= CW'(2)) && entries_q[young_idx].valid
                       && (entries_q[young_idx].word_addr == st_word);
    assign ST_READY  = (count_q != CW'(DEPTH)) || merge_hit;
`else
    assign merge_hit = 1'b0;
    assign ST_READY  = (count_q != CW'(DEPTH));
`endif

    assign push         = ST_VALID && ST_READY;
    assign alloc        = push && !merge_hit;
    assign MEM_WRITE_EN = (count_q != '0);
    assign pop          = MEM_WRITE_EN && !MEM_BUSYWAIT;

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(alloc);
        count_d = count_q + CW'(alloc) - CW'(pop);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++) entries_q[k] <= '0;
        end else begin
            if (pop) entries_q[head_q].valid <= 1'b0;
            if (alloc) begin
                entries_q[tail_q] <= '{valid: 1'b1, word_addr: st_word, data: ST_DATA,
                                       bmask: ST_BMASK};
            end
            if (push && merge_hit) begin
                for (int i = 0; i < NB; i++) begin
                    if (ST_BMASK[i]) entries_q[young_idx].data[8*i +: 8] <= ST_DATA[8*i +: 8];
                end
                entries_q[young_idx].bmask <= entries_q[young_idx].bmask | ST_BMASK;
            end
        end
    end

    assign COUNT         = count_q;
    assign MEM_ADDR      = MEM_WRITE_EN ? {head_e.word_addr, 2'b00} : '0;
    assign MEM_WRITEDATA = MEM_WRITE_EN ? head_e.data : '0;
    assign MEM_BMASK     = MEM_WRITE_EN ? head_e.bmask : '0;

    logic [NB-1:0][DEPTH-1:0]      lane_hit;
    logic [NB-1:0][DEPTH-1:0][7:0] lane_byte;
    logic [DEPTH-1:0][PW-1:0]      ages;
    logic [NB-1:0]                 lane_cov;
    logic [NB-1:0][7:0]            lane_out;

    always_comb begin
        lane_hit  = '0;
        lane_byte = '0;
        ages      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ages[k] = PW'(age_of(32'(k), 32'(head_q), 32'(DEPTH)));
            for (int i = 0; i < NB; i++) begin
                lane_hit[i][k]  = LD_VALID && LD_BMASK[i] && entries_q[k].valid
                                  && entries_q[k].bmask[i] && (entries_q[k].word_addr == ld_word);
                lane_byte[i][k] = entries_q[k].data[8*i +: 8];
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_lane
        mem_fwd_lane_sel #(.DEPTH(DEPTH)) u_sel (
            .hit_i  (lane_hit[g]),
            .byte_i (lane_byte[g]),
            .age_i  (ages),
            .cov_o  (lane_cov[g]),
            .byte_o (lane_out[g])
        );
    end

    assign LD_DATA    = lane_out;
    assign LD_HIT     = (lane_cov != '0) && (lane_cov == LD_BMASK);
    assign LD_PARTIAL = (lane_cov != '0) && (lane_cov != LD_BMASK);

endmodule

// File: tb/tb_mem_store_fwd_buffer.sv
// Directed bench for mem_store_fwd_buffer (DEPTH=4, 32-bit); coalescing checks follow MEM_FWD_COALESCE_EN.
module tb_mem_store_fwd_buffer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ST_VALID, ST_READY;
    logic [31:0] ST_ADDR, ST_DATA;
    logic [3:0]  ST_BMASK;
    logic        LD_VALID;
    logic [31:0] LD_ADDR;
    logic [3:0]  LD_BMASK;
    logic        LD_HIT, LD_PARTIAL;
    logic [31:0] LD_DATA;
    logic        MEM_WRITE_EN;
    logic [31:0] MEM_ADDR, MEM_WRITEDATA;
    logic [3:0]  MEM_BMASK;
    logic        MEM_BUSYWAIT;
    logic [2:0]  COUNT;

    int total = 0;
    int bad   = 0;

    mem_store_fwd_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .ST_VALID(ST_VALID), .ST_READY(ST_READY), .ST_ADDR(ST_ADDR), .ST_DATA(ST_DATA),
        .ST_BMASK(ST_BMASK),
        .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR), .LD_BMASK(LD_BMASK),
        .LD_HIT(LD_HIT), .LD_PARTIAL(LD_PARTIAL), .LD_DATA(LD_DATA),
        .MEM_WRITE_EN(MEM_WRITE_EN), .MEM_ADDR(MEM_ADDR), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_BMASK(MEM_BMASK), .MEM_BUSYWAIT(MEM_BUSYWAIT), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        ST_VALID = 1'b1; ST_ADDR = a; ST_DATA = d; ST_BMASK = m;
        step();
        ST_VALID = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] m);
        LD_VALID = 1'b1; LD_ADDR = a; LD_BMASK = m;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_a [4];
        logic [31:0] ea;
        RESET = 1'b0; ST_VALID = 1'b0; ST_ADDR = '0; ST_DATA = '0; ST_BMASK = '0;
        LD_VALID = 1'b0; LD_ADDR = '0; LD_BMASK = '0; MEM_BUSYWAIT = 1'b1;
        #3;
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_we", 32'(MEM_WRITE_EN), 0);
        chk("rst_memaddr", MEM_ADDR, 0);
        chk("rst_ldhit", 32'(LD_HIT), 0);
        #4 RESET = 1'b1;
        step();

        // Reset with three entries queued
        push(32'h100, 32'hDEADBEEF, 4'hF);
        push(32'h104, 32'h1, 4'hF);
        push(32'h108, 32'h2, 4'hF);
        chk("q3_count", 32'(COUNT), 3);
        chk("q3_memaddr", MEM_ADDR, 32'h100);
        #2 RESET = 1'b0;
        #1;
        chk("async_count", 32'(COUNT), 0);
        chk("async_we", 32'(MEM_WRITE_EN), 0);
        RESET = 1'b1;
        step();
        ld(32'h100, 4'hF);
        chk("postrst_hit", 32'(LD_HIT), 0);
        chk("postrst_partial", 32'(LD_PARTIAL), 0);
        LD_VALID = 1'b0;

        // Full forward
        push(32'h100, 32'hDEADBEEF, 4'hF);
        ld(32'h100, 4'hF);
        chk("ff_hit", 32'(LD_HIT), 1);
        chk("ff_partial", 32'(LD_PARTIAL), 0);
        chk("ff_data", LD_DATA, 32'hDEADBEEF);
        ld(32'h104, 4'hF);
        chk("miss_hit", 32'(LD_HIT), 0);
        chk("miss_partial", 32'(LD_PARTIAL), 0);
        LD_VALID = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        step();
        MEM_BUSYWAIT = 1'b1;
        chk("drain1_count", 32'(COUNT), 0);

        // Youngest wins per lane
        push(32'h101, 32'h0000AA00, 4'b0010);
        push(32'h101, 32'h00005500, 4'b0010);
        ld(32'h101, 4'b0010);
        chk("yw_hit", 32'(LD_HIT), 1);
        chk("yw_data", LD_DATA, 32'h00005500);
        ld(32'h100, 4'hF);
        chk("yw_partial", 32'(LD_PARTIAL), 1);
        chk("yw_lw_hit", 32'(LD_HIT), 0);
        chk("yw_lw_data", LD_DATA, 32'h00005500);
        LD_VALID = 1'b0;
        #1;
        chk("ldvalid0_hit", 32'(LD_HIT), 0);
        chk("head_addr", MEM_ADDR, 32'h100);
        chk("head_data", MEM_WRITEDATA, 32'h0000AA00);
        chk("head_bmask", 32'(MEM_BMASK), 32'h2);

        // Fill under busywait
        push(32'h300, 32'h1, 4'hF);
        push(32'h304, 32'h2, 4'hF);
        chk("full_count", 32'(COUNT), 4);
        chk("full_ready", 32'(ST_READY), 0);
        push(32'h308, 32'h3, 4'hF);
        chk("full_nopush", 32'(COUNT), 4);
        chk("full_headstable", MEM_ADDR, 32'h100);
        MEM_BUSYWAIT = 1'b0;
        step();
        MEM_BUSYWAIT = 1'b1;
        chk("rel_count", 32'(COUNT), 3);
        chk("rel_ready", 32'(ST_READY), 1);
        chk("rel_headdata", MEM_WRITEDATA, 32'h00005500);

        // Same-cycle push is invisible to the load
        ST_VALID = 1'b1; ST_ADDR = 32'h400; ST_DATA = 32'h12345678; ST_BMASK = 4'hF;
        ld(32'h400, 4'hF);
        chk("nobypass_hit", 32'(LD_HIT), 0);
        step();
        ST_VALID = 1'b0;
        #1;
        chk("after_push_hit", 32'(LD_HIT), 1);
        chk("after_push_data", LD_DATA, 32'h12345678);
        chk("after_push_count", 32'(COUNT), 4);

        // Head popping this cycle is still searched
        MEM_BUSYWAIT = 1'b0;
        ld(32'h101, 4'b0010);
        chk("popping_hit", 32'(LD_HIT), 1);
        chk("popping_data", LD_DATA, 32'h00005500);
        LD_VALID = 1'b0;

        // Drain order
        exp_a = '{32'h100, 32'h300, 32'h304, 32'h400};
        for (int n = 0; n < 4; n++) begin
            chk("drain_order", MEM_ADDR, exp_a[n]);
            step();
        end
        chk("drained_count", 32'(COUNT), 0);
        chk("drained_we", 32'(MEM_WRITE_EN), 0);

        // Push and pop together at COUNT = 2, across pointer wrap
        MEM_BUSYWAIT = 1'b1;
        push(32'h500, 32'hA0, 4'hF);
        push(32'h504, 32'hB0, 4'hF);
        MEM_BUSYWAIT = 1'b0;
        for (int n = 0; n < 6; n++) begin
            ST_VALID = 1'b1; ST_ADDR = 32'h600 + 32'(4 * n); ST_DATA = 32'(n); ST_BMASK = 4'hF;
            #1;
            ea = (n < 2) ? 32'h500 + 32'(4 * n) : 32'h600 + 32'(4 * (n - 2));
            chk("pp_head", MEM_ADDR, ea);
            step();
            chk("pp_count", 32'(COUNT), 2);
        end
        ST_VALID = 1'b0;
        for (int n = 0; n < 2; n++) begin
            chk("pp_tail_addr", MEM_ADDR, 32'h610 + 32'(4 * n));
            chk("pp_tail_data", MEM_WRITEDATA, 32'(4 + n));
            step();
        end
        chk("pp_empty", 32'(COUNT), 0);

        // Coalescing into the youngest entry
        MEM_BUSYWAIT = 1'b1;
        push(32'h180, 32'h77, 4'b0001);
        push(32'h200, 32'h11, 4'b0001);
        push(32'h201, 32'h2200, 4'b0010);
        ld(32'h200, 4'b0011);
        chk("co_ld_hit", 32'(LD_HIT), 1);
        chk("co_ld_data", LD_DATA, 32'h2211);
        LD_VALID = 1'b0;
`ifdef MEM_FWD_COALESCE_EN
        chk("co_count", 32'(COUNT), 2);
`else
        chk("co_count", 32'(COUNT), 3);
`endif
        MEM_BUSYWAIT = 1'b0;
        step();
        MEM_BUSYWAIT = 1'b1;
        chk("co_head_addr", MEM_ADDR, 32'h200);
`ifdef MEM_FWD_COALESCE_EN
        chk("co_bmask", 32'(MEM_BMASK), 32'h3);
        chk("co_data", MEM_WRITEDATA & 32'hFFFF, 32'h2211);
`else
        chk("co_bmask", 32'(MEM_BMASK), 32'h1);
        chk("co_data", MEM_WRITEDATA, 32'h11);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
